inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Instruction-fetch front end feeding the decode stage. Decode extracts immediates and branch offsets from the fetched word.
- Holds the PC and issues sequential word requests to instruction memory. Memory latency is variable; responses return in order.
- Buffers returned instructions in a small FIFO and presents {inst, pc} to decode with a valid/ready handshake.
- On a branch/jump redirect: flushes the FIFO, discards in-flight responses and restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h1c00_0000, first fetch address after reset.
- DEPTH, 4, FIFO entries and maximum outstanding requests; power of two, ≥2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rstn  input  1  reset, synchronous, active-low.
- imem_req_valid  output  1  request valid.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  32  request address (current PC).
- imem_rsp_valid  input  1  response valid; one per accepted request, in order, ≥1 cycle after accept.
- imem_rsp_data  input  32  instruction word.
- redirect_valid  input  1  branch/jump taken, one-cycle pulse.
- redirect_pc  input  32  new fetch PC.
- id_valid  output  1  head entry valid to decode.
- id_ready  input  1  decode accepts head.
- id_inst  output  32  head instruction.
- id_pc  output  32  address of head instruction.

Behaviour:
- Reset (rstn=0 at edge):
  - pc = RESET_PC, head_pc = RESET_PC.
  - FIFO count, outstanding, and drop_cnt all = 0.
  - imem_req_valid = 0 and id_valid = 0 while rstn=0.
  - First request is issued in the cycle after rstn rises.
  - A reset mid-operation abandons all in-flight requests; responses arriving after reset are ignored only while drop_cnt covers them, so memory must be reset together with this block.
- Request issue:
  - imem_req_valid = rstn & ~redirect_valid & (count + outstanding < DEPTH).
  - imem_addr = pc.
  - On accept (valid & ready): pc += 4 (mod 2^32) and outstanding += 1.
- Response handling:
  - While drop_cnt > 0: the response is discarded, drop_cnt -= 1, outstanding -= 1.
  - Otherwise: imem_rsp_data is written at the tail, count += 1, outstanding -= 1.
  - The FIFO cannot overflow by construction (credit rule).
  - imem_rsp_valid with outstanding == 0 is a protocol error; it is ignored and changes no state.
- Decode side:
  - id_valid = (count != 0) & ~redirect_valid.
  - id_inst = head entry; id_pc = head_pc.
  - Pop on id_valid & id_ready: head_pc += 4.
  - Push and pop in the same cycle leave count unchanged. Read-during-write on a single-entry FIFO is correct; the head is the old entry.
  - FIFO pointers are log2(DEPTH) bits and wrap naturally.
- Redirect (redirect_valid=1), which has priority over everything:
  - pc = head_pc = {redirect_pc[31:2], 2'b00}.
  - count = 0; no push, no pop, no request this cycle.
  - drop_cnt = outstanding − (imem_rsp_valid & outstanding != 0). The response in this cycle is discarded and counts against outstanding.
  - outstanding is updated the same way.
  - Back-to-back redirects: the latest one wins; drop_cnt is recomputed from outstanding each time.
  - Next cycle: a request to the new PC may issue.
- Throughput: with 1-cycle memory latency and decode always ready, one instruction per cycle is sustained after a 2-cycle startup.
- Counters: count and outstanding are log2(DEPTH)+1 bits; the sum is compared at log2(DEPTH)+2 bits.

Test Plan:
- Reset then free-run, memory latency 1, id_ready=1: addresses 1c000000, 1c000004, 1c000008…; id_valid first at cycle 2 with id_pc=1c000000; one instruction per cycle, id_inst matching memory contents.
- id_ready=0 throughout, memory latency 1: exactly 4 requests accepted (addresses up to 1c00000c), imem_req_valid then stays 0; after id_ready=1, words pop in order with id_pc 1c000000…1c00000c and fetch resumes at 1c000010.
- Memory latency 3, 3 requests in flight, redirect to 1c000103: next request address 1c000100; the 3 stale responses are dropped; the first id_valid has id_pc=1c000100 and the instruction at 1c000100.
- Redirect in the same cycle as a response, id_valid and imem_req_ready: that response is discarded, the FIFO is empty next cycle, and no request is issued in the redirect cycle.
- Two redirects 2 cycles apart (to 1c000200, then 1c000300) with latency 4: only instructions from 1c000300 onward reach decode; drop_cnt returns to 0.
- Wrap: redirect to fffffffc; requests go to fffffffc then 00000000; id_pc follows the same wrap.

Source files
------------

// File: rtl/inst_fetch_queue_if.sv
// Fetch-unit bundle: instruction-memory request/response plus the decode handshake.
interface inst_fetch_queue_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_inst, id_pc,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_inst, id_pc,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
           redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: credit-limited sequential fetch, in-order response
// FIFO toward decode, and redirect flush that drops stale in-flight responses.
module inst_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h1c00_0000,
  parameter int unsigned DEPTH    = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  inst_fetch_queue_if.master    bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned SW = AW + 2;

  logic [31:0]   pc;
  logic [31:0]   head_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop_cnt;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   mem [DEPTH];

  logic req_ok;
  logic head_ok;
  logic req_fire;
  logic rsp_take;
  logic push;
  logic pop;
  logic unused_ok;

  // Credit rule: buffered plus in-flight words never exceed the FIFO depth.
  always_comb begin
    req_ok   = rstn & ~bus.redirect_valid &
               ((SW'(count) + SW'(outstanding)) < SW'(DEPTH));
    head_ok  = rstn & (count != '0) & ~bus.redirect_valid;
    req_fire = req_ok & bus.imem_req_ready;
    rsp_take = bus.imem_rsp_valid & (outstanding != '0);
    push     = rstn & rsp_take & (drop_cnt == '0) & ~bus.redirect_valid;
    pop      = head_ok & bus.id_ready;
  end

  assign bus.imem_req_valid = req_ok;
  assign bus.imem_addr      = pc;
  assign bus.id_valid       = head_ok;
  assign bus.id_inst        = mem[rd_ptr];
  assign bus.id_pc          = head_pc;
  assign unused_ok          = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc          <= RESET_PC;
      head_pc     <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop_cnt    <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else if (bus.redirect_valid) begin
      // Everything still in flight, minus a response landing now, becomes stale.
      pc          <= {bus.redirect_pc[31:2], 2'b00};
      head_pc     <= {bus.redirect_pc[31:2], 2'b00};
      count       <= '0;
      outstanding <= outstanding - CW'(rsp_take);
      drop_cnt    <= outstanding - CW'(rsp_take);
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      if (req_fire) pc <= pc + 32'd4;
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_take);
      if (rsp_take && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr  <= rd_ptr + AW'(1);
        head_pc <= head_pc + 32'd4;
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage has no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.imem_rsp_data;
  end
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Randomized bench for inst_fetch_queue against an epoch-tagged transaction model.
module tb_inst_fetch_queue;
  localparam logic [31:0] RESET_PC = 32'h1c00_0000;
  localparam int unsigned DEPTH    = 4;

  logic clk;
  logic rstn;
  inst_fetch_queue_if bus();

  inst_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: fetch PC, redirect epoch, in-flight requests, decode queue.
  logic [31:0] m_pc;
  int          m_epoch;
  logic [31:0] infl_addr[$];
  int          infl_ep[$];
  logic [31:0] fifo_inst[$];
  logic [31:0] fifo_pc[$];
  // Memory model: accepted addresses with the cycle their response is due.
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  int          last_due;

  // Stimulus knobs
  int lat_lo, lat_hi, p_idr, p_rr, p_redir, p_spur;
  bit          force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9e37_79b1) ^ 32'h5a5a_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %08h expected %08h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset();
    m_pc     = RESET_PC;
    m_epoch  = 0;
    last_due = 0;
    infl_addr.delete(); infl_ep.delete();
    fifo_inst.delete(); fifo_pc.delete();
    pend_addr.delete(); pend_due.delete();
  endtask

  task automatic step(input bit rst_on);
    bit          e_req, e_idv, redir, rsp, keep;
    logic [31:0] a;
    int          ep, due;
    @(negedge clk);
    rstn = ~rst_on;
    if (force_redir) begin
      redir = 1'b1; bus.redirect_pc = force_pc; force_redir = 1'b0;
    end else begin
      redir = ($urandom_range(99) < p_redir);
      bus.redirect_pc = $urandom;
    end
    bus.redirect_valid = redir;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = inst_of(pend_addr[0]);
    end else begin
      // Occasional protocol-error response with nothing outstanding.
      bus.imem_rsp_valid = (pend_addr.size() == 0) && ($urandom_range(99) < p_spur);
      bus.imem_rsp_data  = $urandom;
    end
    rsp = bus.imem_rsp_valid;
    bus.id_ready       = ($urandom_range(99) < p_idr);
    bus.imem_req_ready = ($urandom_range(99) < p_rr);
    #1;
    e_req = !rst_on && !redir && (fifo_inst.size() + infl_addr.size() < DEPTH);
    e_idv = !rst_on && !redir && (fifo_inst.size() != 0);
    check("imem_req_valid", 32'(bus.imem_req_valid), 32'(e_req));
    if (e_req) check("imem_addr", bus.imem_addr, m_pc);
    check("id_valid", 32'(bus.id_valid), 32'(e_idv));
    if (e_idv) begin
      check("id_inst", bus.id_inst, fifo_inst[0]);
      check("id_pc", bus.id_pc, fifo_pc[0]);
    end
    if (rst_on) begin
      model_reset();
    end else begin
      if (e_idv && bus.id_ready && !redir) begin
        void'(fifo_inst.pop_front()); void'(fifo_pc.pop_front());
      end
      if (rsp && infl_addr.size() > 0) begin
        a  = infl_addr.pop_front();
        ep = infl_ep.pop_front();
        void'(pend_addr.pop_front()); void'(pend_due.pop_front());
        keep = (ep == m_epoch) && !redir;
        if (keep) begin
          fifo_inst.push_back(inst_of(a));
          fifo_pc.push_back(a);
        end
      end
      if (redir) begin
        m_epoch++;
        fifo_inst.delete(); fifo_pc.delete();
        m_pc = {bus.redirect_pc[31:2], 2'b00};
      end else if (e_req && bus.imem_req_ready) begin
        infl_addr.push_back(m_pc);
        infl_ep.push_back(m_epoch);
        due = cyc + int'($urandom_range(lat_hi, lat_lo));
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        pend_addr.push_back(m_pc);
        pend_due.push_back(due);
        m_pc = m_pc + 32'd4;
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input int llo, input int lhi, input int idr,
                     input int rr, input int rd, input int sp);
    lat_lo = llo; lat_hi = lhi; p_idr = idr; p_rr = rr; p_redir = rd; p_spur = sp;
    for (int i = 0; i < n; i++) step(1'b0);
  endtask

  task automatic redirect_to(input logic [31:0] target);
    force_redir = 1'b1;
    force_pc    = target;
    step(1'b0);
  endtask

  initial begin
    rstn = 1'b0;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = '0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.id_ready = 1'b0;
    force_redir = 1'b0; force_pc = '0;
    lat_lo = 1; lat_hi = 1; p_idr = 100; p_rr = 100; p_redir = 0; p_spur = 0;
    model_reset();
    for (int i = 0; i < 3; i++) step(1'b1);

    // Free run, latency 1, decode always ready.
    run(30, 1, 1, 100, 100, 0, 0);
    // Decode stalled: credit limit, then drain in order.
    for (int i = 0; i < 2; i++) step(1'b1);
    run(12, 1, 1, 0, 100, 0, 0);
    run(12, 1, 1, 100, 100, 0, 0);
    // Latency 3, redirect to an unaligned target with requests in flight.
    run(6, 3, 3, 100, 100, 0, 0);
    redirect_to(32'h1c00_0103);
    run(20, 3, 3, 100, 100, 0, 0);
    // Redirect while a response, a valid head and a ready memory coincide.
    run(6, 1, 1, 100, 100, 0, 0);
    redirect_to(32'h1c00_0040);
    run(10, 1, 1, 100, 100, 0, 0);
    // Two redirects two cycles apart with latency 4.
    run(6, 4, 4, 100, 100, 0, 0);
    redirect_to(32'h1c00_0200);
    run(1, 4, 4, 100, 100, 0, 0);
    redirect_to(32'h1c00_0300);
    run(25, 4, 4, 100, 100, 0, 0);
    // Address wrap.
    redirect_to(32'hffff_fffc);
    run(12, 1, 1, 100, 100, 0, 0);
    // Random traffic, including spurious responses and a mid-run reset.
    run(1500, 1, 5, 70, 70, 4, 5);
    for (int i = 0; i < 2; i++) step(1'b1);
    run(1500, 1, 3, 50, 80, 8, 5);
    run(300, 1, 6, 90, 90, 25, 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
